// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts one key/block request, walks the round index
// fed to keygen (reversed for decrypt) and holds the result until consumed.
module des_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_key,
  input  logic             in_decrypt,
  input  logic             abort,
  output logic [63:0]      key,
  output logic [CNT_W-1:0] cnt,
  output logic             load,
  output logic             round_en,
  output logic             last_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] r_q, r_d;
  logic [63:0]      key_q, key_d;
  logic             dec_q, dec_d;
  logic             rdy_q, rdy_d;
  logic [15:0]      done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = '0;
    key_d   = key_q;
    dec_d   = dec_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          state_d = LOAD;
          key_d   = in_key;
          dec_d   = in_decrypt;
        end
      end
      LOAD: state_d = abort ? IDLE : ROUND;
      ROUND: begin
        if (abort)            state_d = IDLE;
        else if (r_q == LAST) state_d = DONE;
        else                  r_d = r_q + CNT_W'(1);
      end
      DONE: begin
        // abort wins over a coincident output handshake
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
          done_d  = done_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // ready is registered so it stays low for the cycle right after reset
    rdy_d = (state_d == IDLE);
  end

  assign in_ready   = rdy_q;
  assign key        = key_q;
  assign load       = (state_q == LOAD);
  assign round_en   = (state_q == ROUND);
  assign last_round = (state_q == ROUND) && (r_q == LAST);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign done_cnt   = done_q;
  assign cnt        = (state_q != ROUND) ? '0 : (dec_q ? LAST - r_q : r_q);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: timeline model checked every cycle plus directed
// literal expectations for sequences, latency, backpressure, abort and reset.
module tb_des_round_ctrl;
  localparam int R  = 16;
  localparam int CW = 5;
  localparam logic [63:0] K1 = 64'h0E01C00038003808;
  localparam logic [63:0] K2 = 64'h133457799BBCDFF1;
  localparam logic [63:0] K3 = 64'hA5A5_5A5A_0F0F_F0F0;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_decrypt = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [63:0] in_key = '0;
  logic in_ready, load, round_en, last_round, out_valid, busy;
  logic [63:0] key;
  logic [CW-1:0] cnt;
  logic [15:0] done_cnt;

  des_round_ctrl #(.ROUNDS(R), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_decrypt(in_decrypt), .abort(abort), .key(key),
    .cnt(cnt), .load(load), .round_en(round_en), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0, preload_req = 1'b0;

  // Model: age counts cycles since acceptance (1 = load cycle).
  bit m_act = 1'b0, m_dec = 1'b0, m_rdy = 1'b0;
  int m_age = 0, m_done = 0;
  logic [63:0] m_key = '0;

  always @(posedge clk) begin : model
    bit a;
    int g, d;
    a = m_act; g = m_age; d = m_done;
    if (rst) begin
      m_act <= 1'b0; m_age <= 0; m_key <= '0; m_dec <= 1'b0;
      m_done <= 0; m_rdy <= 1'b0;
    end else begin
      if (!a) begin
        if (in_valid && m_rdy) begin
          a = 1'b1; g = 1;
          m_key <= in_key; m_dec <= in_decrypt;
        end
      end else if (abort) begin
        a = 1'b0;
      end else if (g >= R + 2) begin
        if (out_ready) begin a = 1'b0; d = (d + 1) % 65536; end
      end else begin
        g = g + 1;
      end
      if (preload_req) d = 65535;
      m_act <= a; m_age <= g; m_done <= d; m_rdy <= !a;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit e_ld, e_re, e_lr, e_ov;
        int ri, ec;
        e_ld = m_act && m_age == 1;
        e_re = m_act && m_age >= 2 && m_age <= R + 1;
        ri   = m_age - 2;
        ec   = e_re ? (m_dec ? R - 1 - ri : ri) : 0;
        e_lr = e_re && ri == R - 1;
        e_ov = m_act && m_age >= R + 2;
        chk("m_in_ready", in_ready, m_rdy);
        chk("m_load", load, e_ld);
        chk("m_round_en", round_en, e_re);
        chk("m_last_round", last_round, e_lr);
        chk("m_out_valid", out_valid, e_ov);
        chk("m_busy", busy, m_act);
        chk("m_cnt", cnt, ec);
        chk("m_key", key, m_key);
        chk("m_done_cnt", done_cnt, m_done);
      end
    end
  endtask

  int lat, lastc, nre;
  int cap[$], enc_seq[$];

  task automatic start(input logic [63:0] k, input bit d);
    int t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    in_valid = 1'b1; in_key = k; in_decrypt = d;
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_after_accept", load, 1);
  endtask

  // Walks from the load cycle to out_valid (or aborts at the Nth round cycle).
  task automatic track(input int abort_at);
    cap.delete(); lat = 1; lastc = -1; nre = 0;
    while (!out_valid && lat < 60) begin
      if (round_en) begin
        cap.push_back(int'(cnt)); nre++;
        if (last_round) lastc = int'(cnt);
        if (nre == abort_at) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          return;
        end
      end
      @(negedge clk); lat++;
    end
    if (!out_valid) chk("out_valid_timeout", out_valid, 1);
  endtask

  task automatic stimulus();
    int t;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key", key, 0);
    chk("rst_done", done_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);

    // encrypt
    out_ready = 1'b1;
    start(K1, 1'b0); track(0);
    chk("enc_latency", lat, 18);
    chk("enc_nrounds", cap.size(), 16);
    for (int i = 0; i < 16; i++) chk("enc_cnt_seq", cap[i], i);
    chk("enc_last_cnt", lastc, 15);
    enc_seq = cap;
    @(negedge clk);
    chk("enc_done", done_cnt, 1);
    chk("enc_idle", busy, 0);

    // decrypt
    start(K1, 1'b1); track(0);
    chk("dec_latency", lat, 18);
    chk("dec_nrounds", cap.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("dec_cnt_seq", cap[i], 15 - i);
      chk("dec_rev_enc", cap[i], enc_seq[15 - i]);
    end
    chk("dec_last_cnt", lastc, 0);
    @(negedge clk);
    chk("dec_done", done_cnt, 2);

    // backpressure with a competing request
    out_ready = 1'b0;
    start(K2, 1'b0); track(0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_key = K3;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_key", key, K2);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", done_cnt, 3);
    chk("bp_key_after", key, K2);

    // abort coinciding with out_ready in DONE
    out_ready = 1'b0;
    start(K1, 1'b0); track(0);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_cnt", done_cnt, 3);
    chk("abort_done_busy", busy, 0);

    // abort at 7th round cycle, then a normal request
    start(K2, 1'b1); track(7);
    chk("abort_rnd_seen", cap.size(), 7);
    chk("abort_rnd_cnt", cap[6], 9);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_done", done_cnt, 3);
    repeat (3) begin @(negedge clk); chk("abort_no_valid", out_valid, 0); end
    start(K3, 1'b0); track(0);
    chk("post_abort_latency", lat, 18);
    @(negedge clk);
    chk("post_abort_done", done_cnt, 4);

    // reset mid-round
    start(K1, 1'b0);
    t = 0;
    while (!(round_en && cnt == 5'd9) && t < 40) begin @(negedge clk); t++; end
    chk("rst_reach_cnt9", cnt, 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_key", key, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_round_en", round_en, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_done", done_cnt, 0);
    @(negedge clk);
    chk("mid_rst_ready_next", in_ready, 1);

    // done_cnt wrap after 65535 completions
    chk_en = 1'b0;
    force dut.done_q = 16'hFFFF;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    release dut.done_q;
    chk_en = 1'b1;
    chk("preload_val", done_cnt, 16'hFFFF);
    start(K2, 1'b0); track(0);
    @(negedge clk);
    chk("wrap_done", done_cnt, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fork
      compare_loop();
      stimulus();
      begin
        #200000;
        chk("watchdog", 0, 1);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencing controller for the DES datapath. Accepts one key/block request through a valid/ready handshake, latches the 64-bit key, steps the 5-bit round index that feeds `keygen` through all rounds, and emits per-cycle load/round strobes to the round datapath. For decryption it reverses the index order, so `keygen` produces subkeys K16..K1. It presents a held result-valid with backpressure, and replaces the free-running `counter` in the encryption core.

## Interface
- `ROUNDS`, default 16: number of Feistel rounds; legal range 2..16.
- `CNT_W`, default 5: width of the round index driven to `keygen`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: controller can accept a request.
- `in_key` in 64: DES key, sampled on the handshake.
- `in_decrypt` in 1: 1 = decrypt, sampled on the handshake.
- `abort` in 1: cancel the operation in flight.
- `key` out 64: latched key to `keygen.key`.
- `cnt` out CNT_W: round index to `keygen.cnt`.
- `load` out 1: datapath loads the input block (initial permutation).
- `round_en` out 1: datapath performs one round this cycle.
- `last_round` out 1: current round is the final one (no L/R swap).
- `out_valid` out 1: datapath result is stable and valid.
- `out_ready` in 1: consumer accepts the result.
- `busy` out 1: state is not IDLE.
- `done_cnt` out 16: count of completed output handshakes.

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_key`→`key` and `in_decrypt`→`dec`, clear `r`, and go to LOAD.
  - `abort` is ignored in IDLE.
- LOAD: `load`=1 for exactly one cycle, then go to ROUND.
- ROUND:
  - `round_en`=1.
  - Internal counter `r` runs 0..ROUNDS-1 and increments each cycle.
  - `cnt` = `dec` ? ROUNDS-1-r : r.
  - `last_round`=1 when r==ROUNDS-1; the next state is DONE.
- DONE:
  - `out_valid`=1, held until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE and increment `done_cnt`, which wraps 0xFFFF→0x0000.
- `abort`=1 in LOAD, ROUND or DONE: next state is IDLE. `done_cnt` is not incremented and no `out_valid` follows. An abort in DONE coinciding with `out_ready` counts as abort, not completion.
- `key` and `dec` hold stable from acceptance until the next acceptance. `cnt` is 0 in IDLE, LOAD and DONE.
- `in_ready`=0 outside IDLE. There is no overlap: the next request is accepted no earlier than the cycle after the output handshake.
- `busy` = (state != IDLE).
- `rst` asserted mid-operation: the next cycle is IDLE with all registers at their reset values. The datapath must treat the result as discarded.

## Timing
- Reset values (cycle after `rst` sampled high):
  - state IDLE; `key`=0; `cnt`=0; `done_cnt`=0.
  - `load`, `round_en`, `last_round`, `out_valid` and `busy` are 0.
  - `in_ready`=0 while `rst` is high, and 1 from the first cycle after it.
- All outputs are decoded from registered state or counters. There is no combinational input→output path.
- With acceptance at edge T:
  - `load` is high in cycle T+1.
  - `round_en` is high in cycles T+2..T+ROUNDS+1.
  - `last_round` is high in cycle T+ROUNDS+1.
  - `out_valid` rises in cycle T+ROUNDS+2, i.e. 18 cycles with defaults.
- Minimum request-to-request spacing is ROUNDS+3 cycles, reached when `out_ready` is held high.
- `keygen` is combinational. `round_key` for round `cnt` is valid in the same cycle `round_en` is high.

## Test plan
- Encrypt, defaults: key 0x0E01C00038003808, `in_decrypt`=0, `out_ready`=1.
  - `cnt` = 0,1,…,15 on consecutive `round_en` cycles.
  - `last_round` is high with `cnt`=15.
  - `out_valid` appears 18 cycles after the handshake; `done_cnt`=1.
- Decrypt, same key: `cnt` = 15,14,…,0, and `last_round` is high with `cnt`=0. The `round_key` sequence equals the encrypt sequence reversed.
- Backpressure: `out_ready`=0 for 5 cycles in DONE.
  - `out_valid` stays high and `in_ready` stays 0.
  - `in_valid` with a new key is not accepted and `key` is unchanged until the handshake.
- Abort at the 7th `round_en` cycle: the next cycle is IDLE, `busy`=0, `in_ready`=1, no `out_valid`, `done_cnt` unchanged. A following request then runs normally.
- `rst` pulsed during ROUND (`cnt`=9): the next cycle has all outputs at reset values, then `in_ready`=1. Separately, preload 65535 completions: the next output handshake gives `done_cnt`=0.
